// File: rtl/shift194_ctrl.sv
// Sequencer for a downstream 74LS194 universal shift register: loads a seed,
// then issues prescaled ring / Johnson / bounce shift codes until stopped.
module shift194_ctrl #(
  parameter int unsigned PRESCALE = 4
) (
  input  logic       clk,
  input  logic       CR,
  input  logic       start,
  input  logic       stop,
  input  logic [1:0] mode,
  input  logic [3:0] seed,
  input  logic [3:0] steps,
  input  logic       QA,
  input  logic       QD,
  output logic       S1,
  output logic       S0,
  output logic       SR,
  output logic       SL,
  output logic       A,
  output logic       B,
  output logic       C,
  output logic       D,
  output logic       busy,
  output logic       done
);

  localparam int unsigned CW = 8;
  localparam logic [CW-1:0] PMAX = CW'(PRESCALE - 1);

  localparam logic [1:0] M_RING_R  = 2'b00;
  localparam logic [1:0] M_RING_L  = 2'b01;
  localparam logic [1:0] M_JOHNSON = 2'b10;
  localparam logic [1:0] M_BOUNCE  = 2'b11;

  localparam logic [1:0] C_HOLD  = 2'b00;
  localparam logic [1:0] C_RIGHT = 2'b01;
  localparam logic [1:0] C_LEFT  = 2'b10;
  localparam logic [1:0] C_LOAD  = 2'b11;

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [1:0]    mode_q;
  logic [3:0]    steps_q;
  logic [3:0]    leg;
  logic          dir;      // bounce direction: 0 right, 1 left
  logic [1:0]    code_q;
  logic [3:0]    data_q;

  logic [CW-1:0] cnt_n;
  logic [3:0]    leg_n;
  logic          dir_n;
  logic          shift_now;
  logic          leg_term;

  assign {S1, S0}     = code_q;
  assign {A, B, C, D} = data_q;

  function automatic logic [1:0] shift_code(input logic [1:0] m, input logic d);
    logic [1:0] c;
    c = C_RIGHT;
    if (m == M_RING_L || (m == M_BOUNCE && d)) c = C_LEFT;
    return c;
  endfunction

  // Next counter values; the leg counter only advances on shift cycles.
  always_comb begin
    shift_now = (state == RUN) && (cnt == PMAX);
    leg_term  = (leg == steps_q - 4'd1);
    cnt_n     = (cnt == PMAX) ? '0 : cnt + CW'(1);
    leg_n     = leg;
    dir_n     = dir;
    if (shift_now && mode_q == M_BOUNCE) begin
      leg_n = leg_term ? 4'd0 : leg + 4'd1;
      dir_n = leg_term ? ~dir : dir;
    end
  end

  // Serial inputs follow the captured mode; unused input is held low.
  always_comb begin
    SR = 1'b0;
    SL = 1'b0;
    if (state == RUN) begin
      case (mode_q)
        M_RING_R:  SR = QD;
        M_RING_L:  SL = QA;
        M_JOHNSON: SR = ~QD;
        default: begin
          if (dir) SL = QA;
          else     SR = QD;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge CR) begin
    if (!CR) begin
      state   <= IDLE;
      cnt     <= '0;
      mode_q  <= 2'b00;
      steps_q <= 4'd0;
      leg     <= 4'd0;
      dir     <= 1'b0;
      code_q  <= C_HOLD;
      data_q  <= 4'b0000;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !stop) begin
            state   <= LOAD;
            code_q  <= C_LOAD;
            data_q  <= seed;
            mode_q  <= mode;
            steps_q <= steps;
            cnt     <= '0;
            leg     <= 4'd0;
            dir     <= 1'b0;
            busy    <= 1'b1;
          end
        end
        LOAD, RUN: begin
          if (stop) begin
            state  <= IDLE;
            code_q <= C_HOLD;
            cnt    <= '0;
            leg    <= 4'd0;
            dir    <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b1;
          end else if (state == LOAD) begin
            state  <= RUN;
            cnt    <= '0;
            code_q <= (PMAX == '0) ? shift_code(mode_q, dir) : C_HOLD;
          end else begin
            cnt    <= cnt_n;
            leg    <= leg_n;
            dir    <= dir_n;
            code_q <= (cnt_n == PMAX) ? shift_code(mode_q, dir_n) : C_HOLD;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift194_ctrl.sv
// Directed bench: two controllers (PRESCALE 1 and 2) each driving a 74LS194 model.
module tb_shift194_ctrl;

  logic       clk = 1'b0;
  logic       CR = 1'b0;
  logic       start = 1'b0, stop = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [3:0] seed = 4'b0000, steps = 4'd0;

  logic s1_1, s0_1, sr_1, sl_1, a_1, b_1, c_1, d_1, busy_1, done_1;
  logic s1_2, s0_2, sr_2, sl_2, a_2, b_2, c_2, d_2, busy_2, done_2;
  logic [3:0] q1 = 4'b0000, q2 = 4'b0000;   // {QA,QB,QC,QD}

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  shift194_ctrl #(.PRESCALE(1)) dut1 (
    .clk(clk), .CR(CR), .start(start), .stop(stop), .mode(mode), .seed(seed),
    .steps(steps), .QA(q1[3]), .QD(q1[0]), .S1(s1_1), .S0(s0_1), .SR(sr_1),
    .SL(sl_1), .A(a_1), .B(b_1), .C(c_1), .D(d_1), .busy(busy_1), .done(done_1));

  shift194_ctrl #(.PRESCALE(2)) dut2 (
    .clk(clk), .CR(CR), .start(start), .stop(stop), .mode(mode), .seed(seed),
    .steps(steps), .QA(q2[3]), .QD(q2[0]), .S1(s1_2), .S0(s0_2), .SR(sr_2),
    .SL(sl_2), .A(a_2), .B(b_2), .C(c_2), .D(d_2), .busy(busy_2), .done(done_2));

  // 74LS194 behaviour: right shift moves QA->QD with SR entering QA.
  always @(posedge clk) begin
    case ({s1_1, s0_1})
      2'b01: q1 <= {sr_1, q1[3:1]};
      2'b10: q1 <= {q1[2:0], sl_1};
      2'b11: q1 <= {a_1, b_1, c_1, d_1};
      default: q1 <= q1;
    endcase
    case ({s1_2, s0_2})
      2'b01: q2 <= {sr_2, q2[3:1]};
      2'b10: q2 <= {q2[2:0], sl_2};
      2'b11: q2 <= {a_2, b_2, c_2, d_2};
      default: q2 <= q2;
    endcase
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_run(input logic [1:0] md, input logic [3:0] sd, input logic [3:0] st);
    mode = md; seed = sd; steps = st;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
  endtask

  task automatic end_run();
    stop = 1'b1;
    step();
    stop = 1'b0;
    step();
  endtask

  task automatic test_reset();
    tests++;
    if ({s1_1, s0_1} !== 2'b00) begin fails++; $display("FAIL reset_s1s0 got %b exp 00", {s1_1, s0_1}); end
    tests++;
    if (busy_1 !== 1'b0 || done_1 !== 1'b0) begin fails++; $display("FAIL reset_flags got busy=%b done=%b exp 0 0", busy_1, done_1); end
    tests++;
    if ({a_1, b_1, c_1, d_1} !== 4'b0000) begin fails++; $display("FAIL reset_abcd got %b exp 0000", {a_1, b_1, c_1, d_1}); end
  endtask

  task automatic test_ring_right();
    logic [3:0] exp [4] = '{4'b0100, 4'b0010, 4'b0001, 4'b1000};
    logic [3:0] prev;
    mode = 2'b00; seed = 4'b1000; steps = 4'd0;
    start = 1'b1;
    step();
    start = 1'b0;
    tests++;
    if ({s1_2, s0_2} !== 2'b11 || busy_2 !== 1'b1) begin fails++; $display("FAIL ring_load_code got s=%b busy=%b exp 11 1", {s1_2, s0_2}, busy_2); end
    tests++;
    if ({a_2, b_2, c_2, d_2} !== 4'b1000) begin fails++; $display("FAIL ring_load_data got %b exp 1000", {a_2, b_2, c_2, d_2}); end
    step();
    tests++;
    if (q2 !== 4'b1000) begin fails++; $display("FAIL ring_q_seed got %b exp 1000", q2); end
    prev = 4'b1000;
    for (int i = 0; i < 4; i++) begin
      step();
      tests++;
      if (q2 !== prev) begin fails++; $display("FAIL ring_hold%0d got %b exp %b", i, q2, prev); end
      step();
      tests++;
      if (q2 !== exp[i]) begin fails++; $display("FAIL ring_shift%0d got %b exp %b", i, q2, exp[i]); end
      prev = exp[i];
    end
    end_run();
  endtask

  task automatic test_johnson();
    logic [3:0] exp [8] = '{4'b1000, 4'b1100, 4'b1110, 4'b1111,
                            4'b0111, 4'b0011, 4'b0001, 4'b0000};
    begin_run(2'b10, 4'b0000, 4'd0);
    // Inputs change mid-run and start is pulsed; neither should disturb the sequence.
    mode = 2'b01; seed = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      if (i == 2) start = 1'b1;
      step();
      start = 1'b0;
      tests++;
      if (q1 !== exp[i]) begin fails++; $display("FAIL johnson%0d got %b exp %b", i, q1, exp[i]); end
    end
    tests++;
    if ({s1_1, s0_1} !== 2'b01 || busy_1 !== 1'b1) begin fails++; $display("FAIL johnson_busy_code got s=%b busy=%b exp 01 1", {s1_1, s0_1}, busy_1); end
    end_run();
  endtask

  task automatic test_bounce();
    logic [3:0] exp [7] = '{4'b0100, 4'b0010, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100};
    begin_run(2'b11, 4'b1000, 4'd3);
    for (int i = 0; i < 7; i++) begin
      step();
      tests++;
      if (q1 !== exp[i]) begin fails++; $display("FAIL bounce3_%0d got %b exp %b", i, q1, exp[i]); end
    end
    end_run();
  endtask

  task automatic test_bounce16();
    int rights;
    rights = 0;
    begin_run(2'b11, 4'b1000, 4'd0);
    for (int i = 0; i < 16; i++) begin
      if ({s1_1, s0_1} == 2'b01) rights++;
      step();
    end
    tests++;
    if (rights != 16) begin fails++; $display("FAIL bounce16_rights got %0d exp 16", rights); end
    tests++;
    if ({s1_1, s0_1} !== 2'b10 || q1 !== 4'b1000) begin fails++; $display("FAIL bounce16_turn got s=%b q=%b exp 10 1000", {s1_1, s0_1}, q1); end
    step();
    tests++;
    if (q1 !== 4'b0001) begin fails++; $display("FAIL bounce16_left got %b exp 0001", q1); end
    end_run();
  endtask

  task automatic test_stop();
    begin_run(2'b00, 4'b1000, 4'd0);
    repeat (4) step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    tests++;
    if ({s1_1, s0_1} !== 2'b00 || {s1_2, s0_2} !== 2'b00) begin fails++; $display("FAIL stop_code got %b %b exp 00 00", {s1_1, s0_1}, {s1_2, s0_2}); end
    tests++;
    if (done_1 !== 1'b1 || busy_1 !== 1'b0 || done_2 !== 1'b1) begin fails++; $display("FAIL stop_done got done=%b busy=%b done2=%b exp 1 0 1", done_1, busy_1, done_2); end
    tests++;
    if (q1 !== 4'b0100 || q2 !== 4'b0010) begin fails++; $display("FAIL stop_q got %b %b exp 0100 0010", q1, q2); end
    step();
    tests++;
    if (done_1 !== 1'b0 || done_2 !== 1'b0) begin fails++; $display("FAIL stop_done_pulse got %b %b exp 0 0", done_1, done_2); end
    tests++;
    if (q1 !== 4'b0100 || q2 !== 4'b0010) begin fails++; $display("FAIL stop_q_hold got %b %b exp 0100 0010", q1, q2); end
  endtask

  task automatic test_start_stop_idle();
    mode = 2'b00; seed = 4'b1111;
    start = 1'b1; stop = 1'b1;
    step();
    tests++;
    if (busy_1 !== 1'b0 || {s1_1, s0_1} !== 2'b00) begin fails++; $display("FAIL idle_startstop got busy=%b s=%b exp 0 00", busy_1, {s1_1, s0_1}); end
    start = 1'b0; stop = 1'b0;
    step();
  endtask

  task automatic test_reset_midrun();
    begin_run(2'b00, 4'b1000, 4'd0);
    repeat (2) step();
    #2 CR = 1'b0;
    #1;
    tests++;
    if ({s1_1, s0_1} !== 2'b00 || busy_1 !== 1'b0 || done_1 !== 1'b0) begin fails++; $display("FAIL async_reset got s=%b busy=%b done=%b exp 00 0 0", {s1_1, s0_1}, busy_1, done_1); end
    tests++;
    if ({a_2, b_2, c_2, d_2} !== 4'b0000 || busy_2 !== 1'b0) begin fails++; $display("FAIL async_reset2 got abcd=%b busy=%b exp 0000 0", {a_2, b_2, c_2, d_2}, busy_2); end
    CR = 1'b1;
    repeat (3) step();
    tests++;
    if (busy_1 !== 1'b0 || done_1 !== 1'b0 || {s1_1, s0_1} !== 2'b00) begin fails++; $display("FAIL reset_wait got busy=%b done=%b s=%b exp 0 0 00", busy_1, done_1, {s1_1, s0_1}); end
  endtask

  initial begin
    #12 CR = 1'b1;
    step();
    test_reset();
    test_ring_right();
    test_johnson();
    test_bounce();
    test_bounce16();
    test_stop();
    test_start_stop_idle();
    test_reset_midrun();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/shift194_ctrl.md
SHIFT194_CTRL -- requirements
Module: shift194_ctrl

Interface
REQ-001 The block SHALL have parameter PRESCALE, default 4, clock cycles per shift event (legal range 1-255).
REQ-002 The block SHALL have input clk, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have input CR, 1 bit, asynchronous active-low reset.
REQ-004 The block SHALL have input start, 1 bit, begin sequence (sampled in IDLE only).
REQ-005 The block SHALL have input stop, 1 bit, end sequence (sampled in LOAD/RUN).
REQ-006 The block SHALL have input mode, 2 bits: 00 ring-right, 01 ring-left, 10 Johnson-right, 11 bounce.
REQ-007 The block SHALL have input seed, 4 bits, parallel load value, seed[3]->A ... seed[0]->D.
REQ-008 The block SHALL have input steps, 4 bits, shifts per bounce leg; 0 means 16.
REQ-009 The block SHALL have inputs QA and QD, 1 bit each, feedback from the downstream 74LS194 outputs.
REQ-010 The block SHALL have outputs S1 and S0, 1 bit each, registered 74LS194 mode code: 00 hold, 01 shift right (QA<-SR), 10 shift left (QD<-SL), 11 load.
REQ-011 The block SHALL have outputs SR and SL, 1 bit each, combinational serial inputs to the 74LS194.
REQ-012 The block SHALL have outputs A, B, C and D, 1 bit each, registered parallel data to the 74LS194.
REQ-013 The block SHALL have outputs busy (1 bit, high in LOAD/RUN) and done (1 bit, one-cycle pulse on completion).

Function
REQ-014 The FSM SHALL have states IDLE, LOAD and RUN.
REQ-015 In IDLE, start=1 and stop=0 SHALL move to LOAD on the next edge; start=1 with stop=1 SHALL remain IDLE.
REQ-016 LOAD SHALL last exactly one cycle: S1S0=11, ABCD=seed; mode, seed and steps are captured; next state RUN.
REQ-017 Captured mode/steps SHALL remain constant until return to IDLE; input changes mid-run have no effect.
REQ-018 In RUN, a prescale counter SHALL count 0..PRESCALE-1 and wrap; S1S0 SHALL carry the shift code only in the cycle where count=PRESCALE-1, else 00.
REQ-019 The first shift cycle SHALL be the PRESCALE-th cycle after LOAD (PRESCALE=1: every RUN cycle shifts).
REQ-020 Ring-right SHALL drive code 01 with SR=QD; ring-left SHALL drive 10 with SL=QA; Johnson-right SHALL drive 01 with SR=~QD.
REQ-021 Bounce SHALL drive `steps` right shifts (01, SR=QD) then `steps` left shifts (10, SL=QA), repeating; a 4-bit leg counter counts shift cycles only and flips direction on terminal count.
REQ-022 Any unused serial input (SR or SL) SHALL be 0.
REQ-023 stop=1 in LOAD or RUN SHALL return to IDLE on the next edge, regardless of prescale phase; done SHALL be 1 for that following cycle only.
REQ-024 A stop coinciding with a shift cycle SHALL still allow that shift (outputs already presented).
REQ-025 start asserted while busy SHALL be ignored.

Reset
REQ-026 CR=0 SHALL immediately force IDLE, S1S0=00, ABCD=0000, busy=0, done=0, all counters 0, independent of clk.
REQ-027 Reset mid-run SHALL abort without a done pulse; after CR rises, the block waits in IDLE for start.

Verification
REQ-028 Reset: CR=0 mid-RUN, no clk edge -> S1S0=00, busy=0, done=0 immediately.
REQ-029 Ring-right, PRESCALE=2, seed=1000, paired with a 74LS194 model -> Q (QA..QD) = 1000, 0100, 0010, 0001, 1000 at every second edge.
REQ-030 Johnson-right, PRESCALE=1, seed=0000 -> Q sequence 1000, 1100, 1110, 1111, 0111, 0011, 0001, 0000.
REQ-031 Bounce, steps=3, PRESCALE=1, seed=1000 -> Q: 0100, 0010, 0001, 0010, 0100, 1000, 0100 ...; steps=0 -> 16 shifts per leg.
REQ-032 stop pulsed on the 5th RUN cycle -> S1S0=00 next cycle, done high exactly one cycle, Q holds; start+stop together in IDLE -> stays IDLE.
